// File: rtl/unpacker_pkg.sv
// Shared definitions for the word/symbol width converters.
// Holds the default datapath widths used by both the packer and unpacker,
// helpers that derive the slice ratio and slice-counter width from a pair
// of widths, and the unpacker state encoding.
package unpacker_pkg;

   localparam int DEFAULT_SIZE_INPUT_BIT  = 32;
   localparam int DEFAULT_SIZE_OUTPUT_BIT = 8;

   // Number of narrow slices that make up one wide word.
   function automatic int calc_ratio(input int in_w, input int out_w);
      return in_w / out_w;
   endfunction

   // Width of the slice counter. It is at least one bit, so that a 1:1
   // ratio still has a legal counter.
   function automatic int calc_cnt_w(input int in_w, input int out_w);
      int r;
      r = in_w / out_w;
      return (r <= 1) ? 1 : $clog2(r);
   endfunction

   localparam int DEFAULT_RATIO = calc_ratio(DEFAULT_SIZE_INPUT_BIT, DEFAULT_SIZE_OUTPUT_BIT);
   localparam int DEFAULT_CNT_W = calc_cnt_w(DEFAULT_SIZE_INPUT_BIT, DEFAULT_SIZE_OUTPUT_BIT);

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

endpackage

// File: rtl/word_unpacker.sv
// Width down-converter: accepts wide words over valid/ready and emits them
// as a stream of narrow symbols, with backpressure on both sides and no
// bubble between back-to-back words.
//
// Ports
//   clk             rising-edge clock
//   reset           synchronous, active-high reset
//   data            input word
//   i_valid_input   input word valid
//   ready           block can take a word this cycle
//   i_ready_output  downstream takes a symbol this cycle
//   bits            output symbol
//   o_valid_output  bits valid
//   o_last          bits is the final slice of the current word
//
// State | Meaning
// ------+---------------------------------------------------------------
// IDLE  | no word held; ready is high, bits is zero
// SEND  | word_q held; slice cnt presented until the downstream takes it
import unpacker_pkg::*;

module word_unpacker #(
   parameter int SIZE_INPUT_BIT  = DEFAULT_SIZE_INPUT_BIT,
   parameter int SIZE_OUTPUT_BIT = DEFAULT_SIZE_OUTPUT_BIT,
   parameter bit MSB_FIRST       = 1'b1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [SIZE_INPUT_BIT-1:0]  data,
   input  logic                       i_valid_input,
   output logic                       ready,
   input  logic                       i_ready_output,
   output logic [SIZE_OUTPUT_BIT-1:0] bits,
   output logic                       o_valid_output,
   output logic                       o_last
);

   localparam int RATIO = calc_ratio(SIZE_INPUT_BIT, SIZE_OUTPUT_BIT);
   localparam int CNT_W = calc_cnt_w(SIZE_INPUT_BIT, SIZE_OUTPUT_BIT);

   if ((SIZE_INPUT_BIT % SIZE_OUTPUT_BIT) != 0) begin : g_bad_ratio
      $error("word_unpacker: SIZE_INPUT_BIT must be a multiple of SIZE_OUTPUT_BIT");
   end

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

   state_t                    state_q, state_d;
   logic [SIZE_INPUT_BIT-1:0] word_q, word_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [CNT_W-1:0]          sel;
   logic                      last_slice;
   logic                      in_fire;
   logic                      out_fire;

   assign last_slice     = (cnt_q == LAST_CNT);
   assign o_valid_output = (state_q == SEND);
   assign o_last         = o_valid_output & last_slice;

   // Combinational from i_ready_output so the next word loads in the same
   // cycle the final slice leaves.
   assign ready    = (state_q == IDLE) | (last_slice & i_ready_output);
   assign in_fire  = i_valid_input & ready;
   assign out_fire = o_valid_output & i_ready_output;

   // Symbol comes only from registered state; no path from data.
   always_comb begin
      sel  = MSB_FIRST ? (LAST_CNT - cnt_q) : cnt_q;
      bits = '0;
      if (state_q == SEND) begin
         bits = word_q[int'(sel)*SIZE_OUTPUT_BIT +: SIZE_OUTPUT_BIT];
      end
   end

   always_comb begin
      state_d = state_q;
      word_d  = word_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_fire) begin
               word_d  = data;
               cnt_d   = '0;
               state_d = SEND;
            end
         end
         SEND: begin
            if (out_fire) begin
               if (last_slice) begin
                  cnt_d = '0;
                  if (in_fire) begin
                     word_d = data;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         word_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         word_q  <= word_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_word_unpacker.sv
// Scoreboard bench for word_unpacker. Two instances (MSB-first and
// LSB-first) share one stimulus; accepted words push their expected
// symbol sequences, and a negedge monitor pops and compares every symbol
// the downstream accepts.
module tb_word_unpacker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] data = '0;
   logic        vin = 1'b0;
   logic        rdy_out = 1'b1;

   logic       ready_m, valid_m, last_m;
   logic [7:0] bits_m;
   logic       ready_l, valid_l, last_l;
   logic [7:0] bits_l;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] exp_m[$];
   logic [8:0] exp_l[$];

   always #5 clk = ~clk;

   word_unpacker #(.SIZE_INPUT_BIT(32), .SIZE_OUTPUT_BIT(8), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .data(data), .i_valid_input(vin), .ready(ready_m),
      .i_ready_output(rdy_out), .bits(bits_m), .o_valid_output(valid_m), .o_last(last_m)
   );

   word_unpacker #(.SIZE_INPUT_BIT(32), .SIZE_OUTPUT_BIT(8), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .data(data), .i_valid_input(vin), .ready(ready_l),
      .i_ready_output(rdy_out), .bits(bits_l), .o_valid_output(valid_l), .o_last(last_l)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Expected symbol order for a word, as {last, symbol}.
   task automatic push_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) begin
         exp_m.push_back({(i == 3), w[31-8*i -: 8]});
         exp_l.push_back({(i == 3), w[8*i +: 8]});
      end
   endtask

   task automatic check_cycle(input string tag, input logic ev, input logic er);
      check({tag, "_valid_msb"}, {31'd0, valid_m}, {31'd0, ev});
      check({tag, "_valid_lsb"}, {31'd0, valid_l}, {31'd0, ev});
      check({tag, "_ready_msb"}, {31'd0, ready_m}, {31'd0, er});
      check({tag, "_ready_lsb"}, {31'd0, ready_l}, {31'd0, er});
      if (!ev) begin
         check({tag, "_idle_bits_msb"}, {24'd0, bits_m}, 32'd0);
         check({tag, "_idle_last_msb"}, {31'd0, last_m}, 32'd0);
      end
   endtask

   always @(negedge clk) begin
      logic [8:0] e;
      if (valid_m && rdy_out) begin
         if (exp_m.size() == 0) begin
            check("msb_unexpected_symbol", {23'd0, last_m, bits_m}, 32'h1ff);
         end else begin
            e = exp_m.pop_front();
            check("msb_symbol", {23'd0, last_m, bits_m}, {23'd0, e});
         end
      end
      if (valid_l && rdy_out) begin
         if (exp_l.size() == 0) begin
            check("lsb_unexpected_symbol", {23'd0, last_l, bits_l}, 32'h1ff);
         end else begin
            e = exp_l.pop_front();
            check("lsb_symbol", {23'd0, last_l, bits_l}, {23'd0, e});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // 1: reset, single word
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      check_cycle("reset", 1'b0, 1'b1);

      data = 32'hA1B2C3D4;
      vin  = 1'b1;
      push_word(data);
      tick();
      vin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_cycle("t1", 1'b1, (i == 3));
         tick();
      end
      check_cycle("t1_end", 1'b0, 1'b1);

      // 3: back-to-back words, no gap
      data = 32'h01020304;
      vin  = 1'b1;
      push_word(data);
      tick();
      data = 32'h05060708;
      push_word(data);
      for (int i = 0; i < 8; i++) begin
         check_cycle("t3", 1'b1, ((i % 4) == 3));
         tick();
         if (i == 3) vin = 1'b0;
      end
      check_cycle("t3_end", 1'b0, 1'b1);

      // 4: downstream stall while B2 is presented
      data = 32'hA1B2C3D4;
      vin  = 1'b1;
      push_word(data);
      tick();
      vin = 1'b0;
      check_cycle("t4_a1", 1'b1, 1'b0);
      tick();
      rdy_out = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("t4_hold_bits_msb", {24'd0, bits_m}, 32'hB2);
         check("t4_hold_bits_lsb", {24'd0, bits_l}, 32'hC3);
         check_cycle("t4_stall", 1'b1, 1'b0);
         tick();
      end
      rdy_out = 1'b1;
      check("t4_resume_bits_msb", {24'd0, bits_m}, 32'hB2);
      check_cycle("t4_b2", 1'b1, 1'b0);
      tick();
      check_cycle("t4_c3", 1'b1, 1'b0);
      tick();
      check_cycle("t4_d4", 1'b1, 1'b1);
      tick();
      check_cycle("t4_end", 1'b0, 1'b1);

      // 5: reset mid-word, then a fresh word
      data = 32'hA1B2C3D4;
      vin  = 1'b1;
      push_word(data);
      tick();
      vin = 1'b0;
      tick();
      tick();
      check("t5_pre_bits_msb", {24'd0, bits_m}, 32'hC3);
      reset = 1'b1;
      tick();
      exp_m.delete();
      exp_l.delete();
      reset = 1'b0;
      check_cycle("t5_after_reset", 1'b0, 1'b1);
      data = 32'hDEADBEEF;
      vin  = 1'b1;
      push_word(data);
      tick();
      vin = 1'b0;
      for (int i = 0; i < 4; i++) begin
         check_cycle("t5", 1'b1, (i == 3));
         tick();
      end
      check_cycle("t5_end", 1'b0, 1'b1);

      // 6: valid pulse while not ready is ignored
      data = 32'hA1B2C3D4;
      vin  = 1'b1;
      push_word(data);
      tick();
      vin     = 1'b0;
      rdy_out = 1'b0;
      data    = 32'hFFFFFFFF;
      vin     = 1'b1;
      check_cycle("t6_blocked", 1'b1, 1'b0);
      tick();
      vin  = 1'b0;
      data = 32'h0;
      check("t6_hold_bits_msb", {24'd0, bits_m}, 32'hA1);
      check("t6_hold_bits_lsb", {24'd0, bits_l}, 32'hD4);
      check_cycle("t6_stall", 1'b1, 1'b0);
      tick();
      rdy_out = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check_cycle("t6", 1'b1, (i == 3));
         tick();
      end
      check_cycle("t6_end", 1'b0, 1'b1);

      check("msb_queue_drained", exp_m.size(), 32'd0);
      check("lsb_queue_drained", exp_l.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
